// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and types for the multi-channel clock divider.
// Rev 1.0
`default_nettype none

package clkdiv_pkg;

  localparam int DIV_W_DEFAULT       = 26;
  localparam int CLK_FREQ_HZ_DEFAULT = 50_000_000;
  localparam int MAX_CH              = 8;
  localparam int MIN_DIV             = 2;

  // One bit wider than a channel index so the channel count itself is representable.
  typedef logic [$clog2(MAX_CH):0] ch_idx_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one programmable divider channel (cnt, div, optional shadow, clk_out, tick).
// Rev 1.0 -- CLKDIV_GLITCHLESS_LOAD_EN defers loads to the next period wrap.
`default_nettype none

module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = CLK_FREQ_HZ_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt_nx;
  logic [DIV_W-1:0] div_nx;
  logic             wrap;
  logic             clk_nx;
  logic             tick_nx;

`ifdef CLKDIV_GLITCHLESS_LOAD_EN
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] shadow_nx;
  logic             pend;
  logic             pend_nx;
`endif

  always_comb begin
    wrap    = en && (cnt == (div - ONE));
    cnt_nx  = cnt;
    div_nx  = div;
    tick_nx = 1'b0;
    if (en) begin
      cnt_nx  = wrap ? '0 : cnt + ONE;
      tick_nx = wrap;
    end
`ifdef CLKDIV_GLITCHLESS_LOAD_EN
    shadow_nx = shadow;
    pend_nx   = pend;
    // A load landing on the wrap itself beats any older shadow value.
    if (wrap) begin
      if (load) begin
        div_nx = load_div;
      end else if (pend) begin
        div_nx = shadow;
      end
      pend_nx = 1'b0;
    end else if (load) begin
      shadow_nx = load_div;
      pend_nx   = 1'b1;
    end
`else
    if (load) begin
      div_nx  = load_div;
      cnt_nx  = '0;
      tick_nx = 1'b0;
    end
`endif
    // Registered together with cnt so clk_out always matches the new count.
    clk_nx = (cnt_nx >= (div_nx >> 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      div     <= RST_DIV;
      clk_out <= 1'b0;
      tick    <= 1'b0;
`ifdef CLKDIV_GLITCHLESS_LOAD_EN
      shadow  <= RST_DIV;
      pend    <= 1'b0;
`endif
    end else begin
      cnt     <= cnt_nx;
      div     <= div_nx;
      clk_out <= clk_nx;
      tick    <= tick_nx;
`ifdef CLKDIV_GLITCHLESS_LOAD_EN
      shadow  <= shadow_nx;
      pend    <= pend_nx;
`endif
    end
  end

`ifdef CLKDIV_GLITCHLESS_LOAD_EN
  assign pending = pend;
`else
  assign pending = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: N_CH programmable clock dividers with load validation.
// Rev 1.0 -- define CLKDIV_GLITCHLESS_LOAD_EN to apply loads at the next period boundary.
`default_nettype none

module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int N_CH        = 2,
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = CLK_FREQ_HZ
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            en,
  input  logic                       load,
  input  logic [sel_width(N_CH)-1:0] load_ch,
  input  logic [DIV_W-1:0]           load_div,
  output logic                       load_err,
  output logic [N_CH-1:0]            pending,
  output logic [N_CH-1:0]            clk_out,
  output logic [N_CH-1:0]            tick
);

  ch_idx_t         ch_idx;
  logic            ch_ok;
  logic            div_ok;
  logic            load_ok;
  logic [N_CH-1:0] load_sel;

  always_comb begin
    ch_idx  = ch_idx_t'(load_ch);
    ch_ok   = (ch_idx < ch_idx_t'(N_CH));
    div_ok  = (load_div >= DIV_W'(MIN_DIV));
    load_ok = load && ch_ok && div_ok;
  end

  // Rejected loads touch no channel; they only raise a one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load && !load_ok;
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign load_sel[i] = load_ok && (ch_idx == ch_idx_t'(i));

      clkdiv_channel #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_channel (
        .clk      (clk),
        .reset    (reset),
        .en       (en[i]),
        .load     (load_sel[i]),
        .load_div (load_div),
        .pending  (pending[i]),
        .clk_out  (clk_out[i]),
        .tick     (tick[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: scoreboard bench for multi_clock_divider (DEFAULT_DIV=4, N_CH=2).
// Rev 1.0 -- also covers CLKDIV_GLITCHLESS_LOAD_EN builds.
`default_nettype none

module tb_multi_clock_divider;

  localparam int NCH = 2;
  localparam int DW  = 26;
  localparam int DEF = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    en = 2'b00;
  logic          load = 1'b0;
  logic [0:0]    load_ch = 1'b0;
  logic [DW-1:0] load_div = '0;
  logic          load_err;
  logic [1:0]    pending;
  logic [1:0]    clk_out;
  logic [1:0]    tick;

  // Three-channel instance: a 2-bit channel select can address a non-existent channel.
  logic [2:0]    en3 = 3'b000;
  logic          load3 = 1'b0;
  logic [1:0]    load_ch3 = 2'd0;
  logic          load_err3;
  logic [2:0]    pending3;
  logic [2:0]    clk_out3;
  logic [2:0]    tick3;

  always #10 clk = ~clk;

  multi_clock_divider #(
    .CLK_FREQ_HZ (50_000_000), .N_CH (NCH), .DIV_W (DW), .DEFAULT_DIV (DEF)
  ) dut (
    .clk (clk), .reset (reset), .en (en), .load (load), .load_ch (load_ch),
    .load_div (load_div), .load_err (load_err), .pending (pending),
    .clk_out (clk_out), .tick (tick)
  );

  multi_clock_divider #(
    .CLK_FREQ_HZ (50_000_000), .N_CH (3), .DIV_W (DW), .DEFAULT_DIV (DEF)
  ) dut3 (
    .clk (clk), .reset (reset), .en (en3), .load (load3), .load_ch (load_ch3),
    .load_div (load_div), .load_err (load_err3), .pending (pending3),
    .clk_out (clk_out3), .tick (tick3)
  );

  typedef struct packed {
    logic       load_err;
    logic [1:0] pending;
    logic [1:0] clk_out;
    logic [1:0] tick;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: m_rem counts the cycles left in the current period (div..1).
  int m_rem[2]    = '{DEF, DEF};
  int m_div[2]    = '{DEF, DEF};
  int m_shadow[2] = '{DEF, DEF};
  bit m_pend[2]   = '{1'b0, 1'b0};
  bit m_tick[2]   = '{1'b0, 1'b0};
  bit m_clk[2]    = '{1'b0, 1'b0};

  task automatic model_step();
    bit   ok;
    bit   hit;
    bit   err;
    int   nd;
    obs_t e;
    ok  = load && (load_div >= 2) && (int'(load_ch) < NCH);
    err = !reset && load && !ok;
    for (int ch = 0; ch < NCH; ch++) begin
      hit = ok && (int'(load_ch) == ch);
      if (reset) begin
        m_div[ch]  = DEF;
        m_rem[ch]  = DEF;
        m_tick[ch] = 1'b0;
        m_pend[ch] = 1'b0;
      end else begin
`ifdef CLKDIV_GLITCHLESS_LOAD_EN
        m_tick[ch] = 1'b0;
        if (en[ch] && m_rem[ch] == 1) begin
          m_tick[ch] = 1'b1;
          nd = hit ? int'(load_div) : (m_pend[ch] ? m_shadow[ch] : m_div[ch]);
          m_div[ch]  = nd;
          m_rem[ch]  = nd;
          m_pend[ch] = 1'b0;
        end else begin
          if (en[ch]) m_rem[ch] = m_rem[ch] - 1;
          if (hit) begin
            m_shadow[ch] = int'(load_div);
            m_pend[ch]   = 1'b1;
          end
        end
`else
        nd = 0;
        if (hit) begin
          m_div[ch]  = int'(load_div);
          m_rem[ch]  = m_div[ch] + nd;
          m_tick[ch] = 1'b0;
        end else if (en[ch]) begin
          m_tick[ch] = (m_rem[ch] == 1);
          m_rem[ch]  = (m_rem[ch] == 1) ? m_div[ch] : m_rem[ch] - 1;
        end else begin
          m_tick[ch] = 1'b0;
        end
`endif
      end
      // High for the last ceil(div/2) cycles of each period.
      m_clk[ch] = (m_rem[ch] <= (m_div[ch] + 1) / 2);
    end
    e.load_err = err;
    e.pending  = {m_pend[1], m_pend[0]};
    e.clk_out  = {m_clk[1], m_clk[0]};
    e.tick     = {m_tick[1], m_tick[0]};
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    obs_t e;
    obs_t got;
    model_step();
    @(posedge clk);
    #1;
    got = {load_err, pending, clk_out, tick};
    e   = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL scoreboard t=%0t: got err=%b pend=%b clk=%b tick=%b, required err=%b pend=%b clk=%b tick=%b",
               $time, got.load_err, got.pending, got.clk_out, got.tick,
               e.load_err, e.pending, e.clk_out, e.tick);
    end
  endtask

  // Advance until channel 0 sits at count c (cnt = div - rem).
  task automatic sync_ch0(input int c);
    int guard;
    guard = 0;
    while ((m_div[0] - m_rem[0]) != c && guard < 20) begin
      cycle();
      guard++;
    end
    if ((m_div[0] - m_rem[0]) != c) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sync_ch0: count %0d, required %0d", m_div[0] - m_rem[0], c);
    end
  endtask

  task automatic test_reset();
    logic [1:0] want;
    reset = 1'b1;
    en    = 2'b11;
    repeat (3) cycle();
    n_cmp++;
    if ({clk_out, tick, pending, load_err} !== 7'b0 || {clk_out3, tick3, pending3, load_err3} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_state: got clk=%b tick=%b pend=%b err=%b, required all zero",
               clk_out, tick, pending, load_err);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      want = {1'((k % 4) == 0), 1'((k % 4) >= 2)};
      n_cmp++;
      if ({tick[0], clk_out[0]} !== want) begin
        n_bad++;
        $display("FAIL reset_release k=%0d: got tick/clk=%b, required %b", k, {tick[0], clk_out[0]}, want);
      end
    end
  endtask

  task automatic test_load_immediate();
    logic [1:0] want;
    load     = 1'b1;
    load_ch  = 1'b1;
    load_div = DW'(5);
    cycle();
    load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      want = {1'((k % 5) == 0), 1'((k % 5) >= 2)};
`ifndef CLKDIV_GLITCHLESS_LOAD_EN
      n_cmp++;
      if ({tick[1], clk_out[1]} !== want) begin
        n_bad++;
        $display("FAIL load_div5 k=%0d: got tick/clk=%b, required %b", k, {tick[1], clk_out[1]}, want);
      end
`endif
    end
  endtask

  task automatic test_load_err();
    load     = 1'b1;
    load_ch  = 1'b0;
    load_div = DW'(1);
    cycle();
    load_div = DW'(0);
    load_ch  = 1'b1;
    cycle();
    load = 1'b0;
    repeat (4) cycle();
    load3    = 1'b1;
    load_ch3 = 2'd3;
    load_div = DW'(5);
    cycle();
    n_cmp++;
    if (load_err3 !== 1'b1) begin
      n_bad++;
      $display("FAIL load_err_ch3: got %b, required 1", load_err3);
    end
    load_ch3 = 2'd2;
    cycle();
    n_cmp++;
    if (load_err3 !== 1'b0) begin
      n_bad++;
      $display("FAIL load_ok_ch2: got %b, required 0", load_err3);
    end
    load3 = 1'b0;
    cycle();
    n_cmp++;
    if (load_err3 !== 1'b0 || clk_out3 !== 3'b000 || tick3 !== 3'b000) begin
      n_bad++;
      $display("FAIL dut3_idle: got err=%b clk=%b tick=%b, required zeros", load_err3, clk_out3, tick3);
    end
  endtask

  task automatic test_enable_hold();
    int got;
    got = 0;
    sync_ch0(2);
    for (int k = 1; k <= 12; k++) begin
      en[0] = (k > 3);
      cycle();
      if (tick[0] === 1'b1) begin
        got = k;
        break;
      end
    end
    en = 2'b11;
    n_cmp++;
    if (got != 5) begin
      n_bad++;
      $display("FAIL enable_hold: tick after %0d cycles, required 5", got);
    end
    repeat (8) cycle();
  endtask

  task automatic test_back_to_back();
    load     = 1'b1;
    load_ch  = 1'b0;
    load_div = DW'(3);
    cycle();
    load_ch  = 1'b1;
    load_div = DW'(7);
    cycle();
    load_ch  = 1'b0;
    load_div = DW'(4);
    cycle();
    load = 1'b0;
    repeat (16) cycle();
  endtask

`ifdef CLKDIV_GLITCHLESS_LOAD_EN
  task automatic test_glitchless();
    int got;
    got = 0;
    sync_ch0(1);
    load     = 1'b1;
    load_ch  = 1'b0;
    load_div = DW'(6);
    cycle();
    load = 1'b0;
    n_cmp++;
    if (pending[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL gl_pending_set: got %b, required 1", pending[0]);
    end
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (tick[0] === 1'b1) begin
        got = k;
        break;
      end
    end
    n_cmp++;
    if (got != 2 || pending[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL gl_apply: wrap after %0d pend=%b, required 2 and 0", got, pending[0]);
    end
    repeat (12) cycle();
  endtask

  task automatic test_reset_pending();
    while (m_rem[0] == 1) cycle();
    load     = 1'b1;
    load_ch  = 1'b0;
    load_div = DW'(8);
    cycle();
    load  = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_cmp++;
    if (pending !== 2'b00) begin
      n_bad++;
      $display("FAIL gl_reset_pending: got %b, required 00", pending);
    end
    repeat (8) cycle();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_immediate();
    test_load_err();
    test_enable_hold();
`ifdef CLKDIV_GLITCHLESS_LOAD_EN
    test_glitchless();
    test_reset_pending();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
